// File: rtl/dnu_lut_page_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dnu_lut_page_writer_pkg
//  Description : Shared sizes, FSM encoding and page-address helper for the
//                IB-DNU f0 LUT page writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dnu_lut_page_writer_pkg;

    localparam int QUAN_SIZE       = 3;
    localparam int ENTRY_ADDR      = $clog2(2**(QUAN_SIZE*2-1));
    localparam int MULTI_FRAME_NUM = 2;
    localparam int BANK_NUM        = 1;
    localparam int LUT_PORT_SIZE   = 1;

    localparam int DATA_W     = LUT_PORT_SIZE * BANK_NUM;
    localparam int PAGE_DEPTH = 2**(ENTRY_ADDR-1);
    localparam int IDX_W      = ENTRY_ADDR - 1;

    // Address field split: MSB selects the frame page, the rest indexes it.
    localparam int OFFSET_BIT = ENTRY_ADDR - 1;
    localparam int PAGE_HI    = ENTRY_ADDR - MULTI_FRAME_NUM;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Joins a frame offset and an in-page entry index into a full LUT address.
    function automatic logic [ENTRY_ADDR-1:0] make_page_addr(
        input logic             off,
        input logic [PAGE_HI:0] idx
    );
        make_page_addr = {off, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dnu_lut_page_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dnu_lut_page_writer_if
//  Description : Entry stream (valid/ready) plus replicated LUT RAM write
//                port. The writer uses the slave view, its environment the
//                master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dnu_lut_page_writer_if;
    import dnu_lut_page_writer_pkg::*;

    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic [ENTRY_ADDR-1:0] page_addr_ram_replicate_0;
    logic [ENTRY_ADDR-1:0] page_addr_ram_replicate_1;
    logic [DATA_W-1:0]     ram_write_data_0;
    logic [DATA_W-1:0]     ram_write_data_1;
    logic                  ib_ram_we;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output page_addr_ram_replicate_0,
        output page_addr_ram_replicate_1,
        output ram_write_data_0,
        output ram_write_data_1,
        output ib_ram_we
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  page_addr_ram_replicate_0,
        input  page_addr_ram_replicate_1,
        input  ram_write_data_0,
        input  ram_write_data_1,
        input  ib_ram_we
    );

endinterface
`default_nettype wire

// File: rtl/dnu_lut_page_writer_lut_wr_port_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dnu_lut_page_writer_lut_wr_port_reg
//  Description : Output register stage for the LUT write port; drives one
//                registered {addr, data, we} onto both read replicates.
//  Revision    : 1.0 - initial release
// ============================================================================
module dnu_lut_page_writer_lut_wr_port_reg
    import dnu_lut_page_writer_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [ENTRY_ADDR-1:0] wr_addr,
    input  wire logic [DATA_W-1:0]     wr_data,
    output logic [ENTRY_ADDR-1:0]      addr_0,
    output logic [ENTRY_ADDR-1:0]      addr_1,
    output logic [DATA_W-1:0]          data_0,
    output logic [DATA_W-1:0]          data_1,
    output logic                       we
);

    logic [ENTRY_ADDR-1:0] r_addr;
    logic [DATA_W-1:0]     r_data;
    logic                  r_we;

    // Capture a write; address/data hold their last value between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_we   <= 1'b0;
        end else begin
            r_we <= wr_en;
            if (wr_en) begin
                r_addr <= wr_addr;
                r_data <= wr_data;
            end
        end
    end

    // A single register feeds both replicates so they can never diverge.
    assign addr_0 = r_addr;
    assign addr_1 = r_addr;
    assign data_0 = r_data;
    assign data_1 = r_data;
    assign we     = r_we;

endmodule
`default_nettype wire

// File: rtl/dnu_lut_page_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dnu_lut_page_writer
//  Description : Loads one multi-frame page of the IB-DNU f0 LUT RAM from a
//                valid/ready entry stream, writing both read replicates, and
//                reports completion/abandonment and a completed-page count.
//  Revision    : 1.0 - initial release
// ============================================================================
module dnu_lut_page_writer
    import dnu_lut_page_writer_pkg::*;
(
    input  wire logic               write_clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic               target_offset,
    input  wire logic               abort,
    dnu_lut_page_writer_if.slave    bus,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [7:0]              load_count
);

    logic [1:0]       r_state;
    logic             r_off;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_load_count;
    logic             r_aborted;

    logic                  w_accept;
    logic                  w_last;
    logic [ENTRY_ADDR-1:0] w_wr_addr;

    assign w_accept  = (r_state == ST_LOAD) && bus.in_valid;
    assign w_last    = (r_idx == IDX_W'(PAGE_DEPTH-1));
    assign w_wr_addr = make_page_addr(r_off, r_idx);

    // Page-load sequencer: IDLE waits for start, LOAD counts accepted
    // entries, DONE marks the single completion cycle.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_off        <= 1'b0;
            r_idx        <= '0;
            r_load_count <= 8'd0;
            r_aborted    <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_off   <= target_offset;
                        r_idx   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    // Abort wins over completion; a same-cycle beat is
                    // still written by the port register below.
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_aborted <= 1'b1;
                    end else if (w_accept && w_last) begin
                        r_state      <= ST_DONE;
                        r_load_count <= r_load_count + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == ST_LOAD);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign aborted      = r_aborted;
    assign load_count   = r_load_count;

    dnu_lut_page_writer_lut_wr_port_reg u_wr_port (
        .clk     (write_clk),
        .rst     (rst),
        .wr_en   (w_accept),
        .wr_addr (w_wr_addr),
        .wr_data (bus.in_data),
        .addr_0  (bus.page_addr_ram_replicate_0),
        .addr_1  (bus.page_addr_ram_replicate_1),
        .data_0  (bus.ram_write_data_0),
        .data_1  (bus.ram_write_data_1),
        .we      (bus.ib_ram_we)
    );

endmodule
`default_nettype wire

// File: tb/tb_dnu_lut_page_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dnu_lut_page_writer
//  Description : Self-checking bench for dnu_lut_page_writer: directed page
//                loads compared cycle by cycle against a behavioural model,
//                plus hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dnu_lut_page_writer;
    import dnu_lut_page_writer_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       target_offset;
    logic       abort;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] load_count;

    dnu_lut_page_writer_if bus ();

    dnu_lut_page_writer dut (
        .write_clk     (clk),
        .rst           (rst),
        .start         (start),
        .target_offset (target_offset),
        .abort         (abort),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .load_count    (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: what a page writer must show one cycle after each edge.
    int   m_mode;
    int   m_off;
    int   m_idx;
    int   m_cnt;
    bit   m_we;
    bit   m_ab;
    int   m_addr;
    bit   m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_IDLE; m_off <= 0; m_idx <= 0; m_cnt <= 0;
            m_we <= 1'b0; m_ab <= 1'b0; m_addr <= 0; m_data <= 1'b0;
        end else begin
            m_we <= 1'b0;
            m_ab <= 1'b0;
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode <= M_LOAD; m_off <= int'(target_offset); m_idx <= 0;
                end
                M_LOAD: begin
                    if (bus.in_valid) begin
                        m_we   <= 1'b1;
                        m_addr <= m_off * PAGE_DEPTH + m_idx;
                        m_data <= bus.in_data[0];
                        m_idx  <= m_idx + 1;
                    end
                    if (abort) begin
                        m_mode <= M_IDLE; m_ab <= 1'b1;
                    end else if (bus.in_valid && m_idx == PAGE_DEPTH-1) begin
                        m_mode <= M_DONE; m_cnt <= (m_cnt + 1) % 256;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready",   32'(bus.in_ready),  32'(m_mode == M_LOAD));
            check("busy",       32'(busy),          32'(m_mode != M_IDLE));
            check("done",       32'(done),          32'(m_mode == M_DONE));
            check("aborted",    32'(aborted),       32'(m_ab));
            check("we",         32'(bus.ib_ram_we), 32'(m_we));
            check("addr0",      32'(bus.page_addr_ram_replicate_0), 32'(m_addr));
            check("addr1",      32'(bus.page_addr_ram_replicate_1), 32'(m_addr));
            check("data0",      32'(bus.ram_write_data_0), 32'(m_data));
            check("data1",      32'(bus.ram_write_data_1), 32'(m_data));
            check("load_count", 32'(load_count),    32'(m_cnt));
        end
    end

    // Record observed writes and pulses for the literal checks.
    int   wr_addr_q[$];
    int   wr_data_q[$];
    int   n_done    = 0;
    int   n_done_we = 0;
    int   n_ab      = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ib_ram_we) begin
                wr_addr_q.push_back(int'(bus.page_addr_ram_replicate_0));
                wr_data_q.push_back(int'(bus.ram_write_data_0));
            end
            if (done) begin
                n_done++;
                if (bus.ib_ram_we) n_done_we++;
            end
            if (aborted) n_ab++;
        end
    end

    task automatic run_load(input bit off, input bit gaps, input bit alt,
                            input int abort_at, input int start_at,
                            input int rst_at, input int exp_done);
        int d0;
        d0 = n_done;
        start = 1'b1;
        target_offset = off;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < PAGE_DEPTH; i++) begin
            if (gaps && i > 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            if (i == rst_at) begin
                bus.in_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                check("rst_we",      32'(bus.ib_ram_we), 32'd0);
                check("rst_addr",    32'(bus.page_addr_ram_replicate_0), 32'd0);
                check("rst_ready",   32'(bus.in_ready), 32'd0);
                check("rst_busy",    32'(busy), 32'd0);
                check("rst_done",    32'(done | aborted), 32'd0);
                check("rst_count",   32'(load_count), 32'd0);
                @(negedge clk);
                @(negedge clk);
                #2 rst = 1'b0;
                break;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = alt ? DATA_W'(~i[0]) : DATA_W'($urandom_range(0, 1));
            start = (i == start_at);
            if (i == start_at) target_offset = ~off;
            abort = (i == abort_at);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            target_offset = off;
            if (i == abort_at) break;
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("done_pulses", 32'(n_done - d0), 32'(exp_done));
    endtask

    initial begin
        int w0;
        int a0;
        rst = 1'b1; start = 1'b0; target_offset = 1'b0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_we",    32'(bus.ib_ram_we), 32'd0);
        check("reset_ready", 32'(bus.in_ready), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_count", 32'(load_count), 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Page 1, continuous beats 1,0,1,0...
        w0 = wr_addr_q.size();
        run_load(1'b1, 1'b0, 1'b1, -1, -1, -1, 1);
        check("t1_writes", 32'(wr_addr_q.size() - w0), 32'd16);
        for (int k = 0; k < 16; k++) begin
            check("t1_addr", 32'(wr_addr_q[w0+k]), 32'h10 + 32'(k));
            check("t1_data", 32'(wr_data_q[w0+k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("t1_count", 32'(load_count), 32'd1);
        check("t1_done_with_last_we", 32'(n_done_we), 32'd1);

        // Page 0 with a gap between every beat.
        w0 = wr_addr_q.size();
        run_load(1'b0, 1'b1, 1'b0, -1, -1, -1, 1);
        check("t2_writes", 32'(wr_addr_q.size() - w0), 32'd16);
        for (int k = 0; k < 16; k++)
            check("t2_addr", 32'(wr_addr_q[w0+k]), 32'(k));
        check("t2_count", 32'(load_count), 32'd2);

        // Abort on the 5th beat, then a full load.
        w0 = wr_addr_q.size();
        a0 = n_ab;
        run_load(1'b0, 1'b0, 1'b0, 4, -1, -1, 0);
        check("t3_writes", 32'(wr_addr_q.size() - w0), 32'd5);
        check("t3_last_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'h04);
        check("t3_aborted", 32'(n_ab - a0), 32'd1);
        check("t3_ready", 32'(bus.in_ready), 32'd0);
        check("t3_count", 32'(load_count), 32'd2);
        run_load(1'b1, 1'b0, 1'b0, -1, -1, -1, 1);
        check("t3b_count", 32'(load_count), 32'd3);

        // Start during LOAD with a toggled offset is ignored.
        w0 = wr_addr_q.size();
        run_load(1'b0, 1'b0, 1'b0, -1, 5, -1, 1);
        check("t4_writes", 32'(wr_addr_q.size() - w0), 32'd16);
        for (int k = 0; k < 16; k++)
            check("t4_addr", 32'(wr_addr_q[w0+k]), 32'(k));
        check("t4_count", 32'(load_count), 32'd4);

        // Reset at idx=7, then in_valid in IDLE must not be consumed.
        a0 = n_ab;
        run_load(1'b1, 1'b0, 1'b0, -1, -1, 7, 0);
        check("t5_aborted", 32'(n_ab - a0), 32'd0);
        w0 = wr_addr_q.size();
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_idle_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t5_idle_writes", 32'(wr_addr_q.size() - w0), 32'd0);

        // 256 completed loads wrap load_count back to 0.
        a0 = n_done;
        for (int k = 0; k < 255; k++)
            run_load(k[0], 1'b0, 1'b0, -1, -1, -1, 1);
        check("t6_count_255", 32'(load_count), 32'd255);
        run_load(1'b1, 1'b0, 1'b0, -1, -1, -1, 1);
        check("t6_count_wrap", 32'(load_count), 32'd0);
        check("t6_dones", 32'(n_done - a0), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
